// File: rtl/fb_arb_pkg.sv
// Frame-buffer arbiter shared definitions: default widths, RAM read latency
// and the grant state encoding used by fb_arbiter.
package fb_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 15;  // 160x120 = 19200 words
  localparam int unsigned DATA_W_DEF = 8;   // RGB 3-3-2
  localparam int unsigned RAM_RD_LAT = 1;   // synchronous read, one cycle

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

endpackage

// File: rtl/fb_wrbuf.sv
// Two-entry write FIFO holding {address, data} for deferred frame-RAM writes.
// Only instantiated when FB_WRBUF_EN is defined. A push while full is taken
// only if a pop happens in the same cycle (occupancy unchanged).
module fb_wrbuf #(
  parameter int unsigned W = 23
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o    = (cnt_q == 2'd0);
  assign full_o     = (cnt_q == 2'd2);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 2'd1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 2'd1;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-RAM arbiter: VGA pixel reads always win, datapath writes
// take the remaining cycles. Define FB_WRBUF_EN to add a 2-entry write buffer
// (fb_wrbuf); without it writes go straight to RAM when no read is requested.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_pend;
  logic [ADDR_W-1:0] wr_head_addr;
  logic [DATA_W-1:0] wr_head_data;

`ifdef FB_WRBUF_EN
  logic                     buf_full;
  logic                     buf_empty;
  logic                     buf_push;
  logic                     buf_pop;
  logic [ADDR_W+DATA_W-1:0] buf_head;

  assign wr_ready                     = clr && !buf_full;
  assign buf_push                     = wr_req && wr_ready;
  assign buf_pop                      = (state_d == WR);
  assign wr_pend                      = !buf_empty;
  assign {wr_head_addr, wr_head_data} = buf_head;
  assign busy                         = !buf_empty;

  fb_wrbuf #(
    .W(ADDR_W + DATA_W)
  ) u_wrbuf (
    .clk_i       (clk),
    .rst_ni      (clr),
    .push_i      (buf_push),
    .push_data_i ({wr_addr, wr_data}),
    .pop_i       (buf_pop),
    .pop_data_o  (buf_head),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );
`else
  assign wr_ready     = clr && !pix_req;
  assign wr_pend      = wr_req;
  assign wr_head_addr = wr_addr;
  assign wr_head_data = wr_data;
  assign busy         = 1'b0;
`endif

  // Per-cycle grant: read beats write beats idle; idle holds the last address.
  // Gating with clr keeps every RAM-side output at zero while in reset.
  always_comb begin
    state_d   = IDLE;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (clr) begin
      if (pix_req) begin
        state_d  = RD;
        ram_addr = pix_addr;
      end else if (wr_pend) begin
        state_d   = WR;
        ram_we    = 1'b1;
        ram_addr  = wr_head_addr;
        ram_wdata = wr_head_data;
      end
    end
  end

  // Grant register plus held RAM address/data for idle cycles.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  assign pix_valid = (state_q == RD);
  assign pix_data  = pix_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;
  import fb_arb_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          clr;
  logic          pix_req;
  logic [AW-1:0] pix_addr;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]    mem [0:(1<<AW)-1];
  logic [DW-1:0]    pq [$];
  logic [AW+DW-1:0] wq [$];

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .clr(clr), .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_valid(pix_valid), .pix_data(pix_data), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame RAM model: preload, then 1-cycle synchronous read and write.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[16]   = 8'hE3;
    mem[17]   = 8'h5A;
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (clr !== 1'b1) begin
      pq.delete();
      wq.delete();
    end else begin
      chk("busy", {31'b0, busy}, {31'b0, (wq.size() != 0)});
      if (pix_valid === 1'b1) begin
        if (pq.size() == 0) chk("spurious_pix_valid", {31'b0, pix_valid}, 32'd0);
        else chk("pix_data", {24'b0, pix_data}, {24'b0, pq.pop_front()});
      end
      if (wr_req === 1'b1 && wr_ready === 1'b1) wq.push_back({wr_addr, wr_data});
      if (ram_we === 1'b1) begin
        if (wq.size() == 0) chk("spurious_ram_we", {31'b0, ram_we}, 32'd0);
        else begin
          e = wq.pop_front();
          chk("wr_order_addr", {17'b0, ram_addr}, {17'b0, e[AW+DW-1:DW]});
          chk("wr_order_data", {24'b0, ram_wdata}, {24'b0, e[DW-1:0]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic pr, input logic [AW-1:0] pa, input logic wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    pix_req  = pr;
    pix_addr = pa;
    wr_req   = wr;
    wr_addr  = wa;
    wr_data  = wd;
  endtask

  initial begin
    logic          have;
    logic [AW-1:0] wa, pa;
    logic [DW-1:0] wd;
    clr = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    // Reset state, including with requests present
    chk("rst_pix_valid", {31'b0, pix_valid}, 32'd0);
    chk("rst_pix_data", {24'b0, pix_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    drive(1, 15'h0123, 1, 15'h0456, 8'h77);
    #1;
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", {17'b0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", {24'b0, ram_wdata}, 32'd0);
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    clr = 1'b1;

    // Basic read right after release
    drive(1, 15'h0010, 0, 0, 0);
    pq.push_back(8'hE3);
    #1;
    chk("rd_addr", {17'b0, ram_addr}, 32'h10);
    chk("rd_no_we", {31'b0, ram_we}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rd_valid", {31'b0, pix_valid}, 32'd1);
    chk("rd_data", {24'b0, pix_data}, 32'hE3);
    tick();
    #1;
    chk("rd_valid_drop", {31'b0, pix_valid}, 32'd0);
    chk("idle_addr_hold", {17'b0, ram_addr}, 32'h10);

    // Back-to-back reads
    drive(1, 15'h0010, 0, 0, 0);
    pq.push_back(8'hE3);
    tick();
    drive(1, 15'h0011, 0, 0, 0);
    pq.push_back(8'h5A);
    #1;
    chk("b2b_valid0", {31'b0, pix_valid}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("b2b_valid1", {31'b0, pix_valid}, 32'd1);
    chk("b2b_data1", {24'b0, pix_data}, 32'h5A);
    tick();

    // Read and write requested together: read wins
    drive(1, 15'h0020, 1, 15'h0100, 8'h1C);
    pq.push_back(8'h00);
    #1;
    chk("collide_we", {31'b0, ram_we}, 32'd0);
    chk("collide_addr", {17'b0, ram_addr}, 32'h20);
`ifdef FB_WRBUF_EN
    chk("collide_ready", {31'b0, wr_ready}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("collide_drain_we", {31'b0, ram_we}, 32'd1);
    chk("collide_drain_addr", {17'b0, ram_addr}, 32'h100);
    chk("collide_busy", {31'b0, busy}, 32'd1);
    tick();
    #1;
    chk("collide_busy_fall", {31'b0, busy}, 32'd0);
`else
    chk("collide_ready", {31'b0, wr_ready}, 32'd0);
    tick();
    drive(0, 0, 1, 15'h0100, 8'h1C);
    #1;
    chk("collide_ready2", {31'b0, wr_ready}, 32'd1);
    chk("collide_we2", {31'b0, ram_we}, 32'd1);
    chk("collide_addr2", {17'b0, ram_addr}, 32'h100);
    chk("collide_wdata2", {24'b0, ram_wdata}, 32'h1C);
    tick();
    drive(0, 0, 0, 0, 0);
`endif
    tick();
    chk("collide_mem", {24'b0, mem[15'h0100]}, 32'h1C);

    // No forwarding: read before pending write lands sees old data
    drive(1, 15'h0200, 1, 15'h0200, 8'hFF);
    pq.push_back(8'h00);
    tick();
`ifdef FB_WRBUF_EN
    drive(0, 0, 0, 0, 0);
`else
    drive(0, 0, 1, 15'h0200, 8'hFF);
`endif
    #1;
    chk("nofwd_old", {24'b0, pix_data}, 32'h00);
    tick();
    drive(1, 15'h0200, 0, 0, 0);
    pq.push_back(8'hFF);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("nofwd_new", {24'b0, pix_data}, 32'hFF);
    tick();

`ifdef FB_WRBUF_EN
    // Three back-to-back writes against every-other-cycle reads
    drive(1, 15'h0010, 1, 15'h0300, 8'hA1);
    pq.push_back(8'hE3);
    #1;
    chk("bb_ready0", {31'b0, wr_ready}, 32'd1);
    tick();
    drive(0, 0, 1, 15'h0301, 8'hA2);
    #1;
    chk("bb_ready1", {31'b0, wr_ready}, 32'd1);
    chk("bb_we1", {31'b0, ram_we}, 32'd1);
    tick();
    drive(1, 15'h0011, 1, 15'h0302, 8'hA3);
    pq.push_back(8'h5A);
    #1;
    chk("bb_ready2", {31'b0, wr_ready}, 32'd1);
    chk("bb_we2", {31'b0, ram_we}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("bb_full_ready", {31'b0, wr_ready}, 32'd0);
    chk("bb_we3", {31'b0, ram_we}, 32'd1);
    tick();
    drive(1, 15'h0012, 0, 0, 0);
    pq.push_back(8'h00);
    #1;
    chk("bb_we4", {31'b0, ram_we}, 32'd0);
    chk("bb_busy4", {31'b0, busy}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("bb_we5", {31'b0, ram_we}, 32'd1);
    tick();
    #1;
    chk("bb_busy_fall", {31'b0, busy}, 32'd0);
    chk("bb_mem", {8'b0, mem[15'h0300], mem[15'h0301], mem[15'h0302]}, 32'hA1A2A3);
`endif

    // Mixed traffic: reads every other cycle, writes held until accepted
    have = 1'b0;
    wa   = '0;
    wd   = '0;
    for (int i = 0; i < 16; i++) begin
      if (!have) begin
        wa   = 15'h0400 + 15'($urandom_range(0, 15));
        wd   = 8'($urandom);
        have = 1'b1;
      end
      pa = 15'h0400 + 15'($urandom_range(0, 15));
      drive((i % 2) == 0, pa, 1'b1, wa, wd);
      if ((i % 2) == 0) pq.push_back(mem[pa]);
      #1;
      if (wr_ready) have = 1'b0;
      tick();
    end
    for (int i = 0; i < 8 && have; i++) begin
      drive(0, 0, 1, wa, wd);
      #1;
      if (wr_ready) have = 1'b0;
      tick();
    end
    chk("mix_accept_timeout", {31'b0, have}, 32'd0);
    drive(0, 0, 0, 0, 0);
    repeat (4) tick();

    // Reset with writes buffered and a read in flight
    drive(1, 15'h0010, 1, 15'h0600, 8'h11);
    pq.push_back(8'hE3);
    tick();
    drive(1, 15'h0011, 1, 15'h0601, 8'h22);
    pq.push_back(8'h5A);
    tick();
    drive(0, 0, 0, 0, 0);
    clr = 1'b0;
    #1;
    chk("mrst_pix_valid", {31'b0, pix_valid}, 32'd0);
    chk("mrst_pix_data", {24'b0, pix_data}, 32'd0);
    chk("mrst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("mrst_ram_addr", {17'b0, ram_addr}, 32'd0);
    chk("mrst_ram_wdata", {24'b0, ram_wdata}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_wr_ready", {31'b0, wr_ready}, 32'd0);
    repeat (2) tick();
    clr = 1'b1;
    #1;
    chk("mrst_release_valid", {31'b0, pix_valid}, 32'd0);
    repeat (6) tick();
    chk("mrst_discard", {16'b0, mem[15'h0600], mem[15'h0601]}, 32'd0);

    chk("end_pix_queue", pq.size(), 32'd0);
    chk("end_wr_queue", wq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
